// File: rtl/apb_master.sv
// apb_master -- APB requester for single read/write transfers.
//
// A local command port (i_req/o_cmd_ready handshake) launches one transfer.
// The transfer is sequenced IDLE -> SETUP -> ACCESS. PREADY wait states are
// honoured, and PRDATA/PSLVERR are captured when the slave completes. An
// optional limit on wait states aborts a hung transfer.
//
// Ports
//   i_PCLK, i_PRESETn               clock, synchronous active-low reset
//   i_req, i_write, i_addr, i_wdata command in (held until accepted)
//   o_cmd_ready                     command accepted on i_req && o_cmd_ready
//   o_done, o_rdata, o_err,         completion pulse and status
//   o_timeout
//   o_PSELx, o_PENABLE, o_PWRITE,   APB requester outputs
//   o_PADDR, o_PWDATA
//   i_PREADY, i_PSLVERR, i_PRDATA   APB slave responses
//
// Every output comes straight from a flop. The bus control outputs are
// loaded from the next state, so they line up with the state register.
module apb_master #(
    parameter int WDATA   = 8,
    parameter int WADDR   = 8,
    parameter int TIMEOUT = 16    // ACCESS wait cycles before abort, 0 = never
) (
    input  logic             i_PCLK,
    input  logic             i_PRESETn,
    input  logic             i_req,
    input  logic             i_write,
    input  logic [WADDR-1:0] i_addr,
    input  logic [WDATA-1:0] i_wdata,
    output logic             o_cmd_ready,
    output logic             o_done,
    output logic [WDATA-1:0] o_rdata,
    output logic             o_err,
    output logic             o_timeout,
    output logic             o_PSELx,
    output logic             o_PENABLE,
    output logic             o_PWRITE,
    output logic [WADDR-1:0] o_PADDR,
    output logic [WDATA-1:0] o_PWDATA,
    input  logic             i_PREADY,
    input  logic             i_PSLVERR,
    input  logic [WDATA-1:0] i_PRDATA
);

    // Counter wide enough to hold TIMEOUT; keep one bit when timeout is off.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt;
    logic          accept;
    logic          finish;     // slave completed (PREADY=1 in ACCESS)
    logic          tmo_hit;    // wait-state limit reached

    // State register
    always_ff @(posedge i_PCLK) begin
        if (!i_PRESETn) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    accept  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (i_PREADY) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Wait-state counter. It is cleared in SETUP and only compared in
    // ACCESS. It saturates so that an unlimited wait (TIMEOUT=0) never wraps.
    always_ff @(posedge i_PCLK) begin
        if (!i_PRESETn)
            wait_cnt <= '0;
        else if (state_q == S_SETUP)
            wait_cnt <= '0;
        else if (state_q == S_ACCESS && !i_PREADY && wait_cnt != {CW{1'b1}})
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Registered outputs
    always_ff @(posedge i_PCLK) begin
        if (!i_PRESETn) begin
            o_cmd_ready <= 1'b1;
            o_done      <= 1'b0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            o_timeout   <= 1'b0;
            o_PSELx     <= 1'b0;
            o_PENABLE   <= 1'b0;
            o_PWRITE    <= 1'b0;
            o_PADDR     <= '0;
            o_PWDATA    <= '0;
        end else begin
            o_cmd_ready <= (state_d == S_IDLE);
            o_PSELx     <= (state_d != S_IDLE);
            o_PENABLE   <= (state_d == S_ACCESS);
            o_done      <= finish | tmo_hit;

            // Command fields stay on the bus after completion until the
            // next accept. Status is cleared when a new transfer starts.
            if (accept) begin
                o_PADDR   <= i_addr;
                o_PWRITE  <= i_write;
                o_PWDATA  <= i_wdata;
                o_err     <= 1'b0;
                o_timeout <= 1'b0;
            end

            if (finish) begin
                o_err     <= i_PSLVERR;
                o_timeout <= 1'b0;
                // Read data is only taken from a successful read.
                if (!o_PWRITE && !i_PSLVERR)
                    o_rdata <= i_PRDATA;
            end

            if (tmo_hit) begin
                o_err     <= 1'b1;
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master. A slave model answers with a programmable
// number of wait states. Each accepted command pushes its predicted
// completion (status, read data, latency) to a scoreboard queue. The
// queue is popped and compared when o_done pulses.
module tb_apb_master;

    localparam int TIMEOUT = 16;
    localparam int STUCK   = 999;   // wait count that never completes

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_req = 1'b0, i_write = 1'b0;
    logic [7:0] i_addr = '0, i_wdata = '0;
    logic       o_cmd_ready, o_done, o_err, o_timeout;
    logic [7:0] o_rdata;
    logic       o_PSELx, o_PENABLE, o_PWRITE;
    logic [7:0] o_PADDR, o_PWDATA;
    logic       i_PREADY = 1'b0, i_PSLVERR = 1'b0;
    logic [7:0] i_PRDATA = '0;

    apb_master #(.WDATA(8), .WADDR(8), .TIMEOUT(TIMEOUT)) dut (
        .i_PCLK(clk), .i_PRESETn(rst_n),
        .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_cmd_ready(o_cmd_ready), .o_done(o_done), .o_rdata(o_rdata),
        .o_err(o_err), .o_timeout(o_timeout),
        .o_PSELx(o_PSELx), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE),
        .o_PADDR(o_PADDR), .o_PWDATA(o_PWDATA),
        .i_PREADY(i_PREADY), .i_PSLVERR(i_PSLVERR), .i_PRDATA(i_PRDATA)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic       tmo;
        logic [7:0] rdata;
        int         lat;
        int         acc;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0, n_fail = 0;
    int         cyc = 0, acc_count = 0, done_count = 0;
    int         prev_acc = 0, last_acc = 0;
    int         psel_cnt = 0, pen_cnt = 0, acc_cnt = 0;
    logic [7:0] model_rdata = '0;

    // Slave behaviour of the transfer in flight
    int         cur_waits = 0;
    logic       cur_serr = 1'b0;
    logic [7:0] cur_pd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Accept monitor and scoreboard push. This block runs on the edge,
    // before the DUT's registers update, so it sees the pre-edge handshake.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            model_rdata = '0;
        end else if (i_req && o_cmd_ready) begin
            e.tmo = (TIMEOUT != 0) && (cur_waits >= TIMEOUT);
            e.err = e.tmo | cur_serr;
            if (!e.tmo && !i_write && !cur_serr) model_rdata = cur_pd;
            e.rdata = model_rdata;
            e.lat   = e.tmo ? TIMEOUT + 1 : cur_waits + 2;
            e.acc   = cyc;
            e.wr    = i_write;
            e.addr  = i_addr;
            e.wdata = i_wdata;
            sb.push_back(e);
            acc_count++;
            prev_acc = last_acc;
            last_acc = cyc;
        end
    end

    // Output checks and slave model, on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            psel_cnt = 0;
            pen_cnt  = 0;
        end else begin
            if (o_PSELx) psel_cnt++;
            if (o_PENABLE) pen_cnt++;
            if (o_PENABLE && !o_PSELx) chk("penable_wo_psel", 1, 0);
            if (o_PSELx && !o_PENABLE) begin
                chk("setup_rdy", o_cmd_ready, 0);
                chk("err_clr_at_accept", {o_err, o_timeout}, 0);
                if (sb.size() > 0) begin
                    chk("paddr", o_PADDR, sb[0].addr);
                    chk("pwrite", o_PWRITE, sb[0].wr);
                    chk("pwdata", o_PWDATA, sb[0].wdata);
                end
            end
            if (o_done) begin
                done_count++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("err", o_err, e.err);
                    chk("timeout", o_timeout, e.tmo);
                    chk("rdata", o_rdata, e.rdata);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("psel_cycles", psel_cnt, e.lat);
                    chk("penable_cycles", pen_cnt, e.lat - 1);
                    chk("psel_low_at_done", o_PSELx, 0);
                    chk("rdy_at_done", o_cmd_ready, 1);
                end
                psel_cnt = 0;
                pen_cnt  = 0;
            end
        end
        // Slave model. PRDATA/PSLVERR carry junk while PREADY is low.
        if (o_PSELx && o_PENABLE) begin
            i_PREADY  = (acc_cnt >= cur_waits);
            i_PSLVERR = i_PREADY ? cur_serr : 1'b1;
            i_PRDATA  = i_PREADY ? cur_pd : 8'hEE;
            acc_cnt++;
        end else begin
            i_PREADY  = 1'b0;
            i_PSLVERR = 1'b1;
            i_PRDATA  = 8'hEE;
            acc_cnt   = 0;
        end
    end

    // Drive a command and return just after the edge that accepts it.
    task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input int w, input logic se, input logic [7:0] pd, input bit hold);
        int base;
        base      = acc_count;
        cur_waits = w;
        cur_serr  = se;
        cur_pd    = pd;
        i_write   = wr;
        i_addr    = a;
        i_wdata   = d;
        i_req     = 1'b1;
        for (int k = 0; k < 50 && acc_count == base; k++) begin
            @(posedge clk);
            #1;
        end
        if (acc_count == base) chk("accept_timeout", 0, 1);
        if (!hold) i_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) chk("done_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_ctl", {o_PSELx, o_PENABLE, o_PWRITE, o_done, o_err, o_timeout}, 0);
        chk("rst_addr", o_PADDR, 0);
        chk("rst_wdata", o_PWDATA, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_rdy", o_cmd_ready, 1);
    endtask

    initial begin
        int base, dc;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state();
        @(posedge clk);
        #1;

        // Zero-wait write
        issue(1'b1, 8'h04, 8'hBB, 0, 1'b0, 8'h00, 1'b0);
        wait_idle();
        // Read with two wait states
        issue(1'b0, 8'h04, 8'h00, 2, 1'b0, 8'hBB, 1'b0);
        wait_idle();

        // Back-to-back writes with i_req held high
        base = acc_count;
        issue(1'b1, 8'h05, 8'hCC, 0, 1'b0, 8'h00, 1'b1);
        i_addr  = 8'h06;
        i_wdata = 8'hDD;
        for (int k = 0; k < 20 && acc_count < base + 2; k++) begin
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
        chk("b2b_accepts", acc_count - base, 2);
        chk("b2b_spacing", last_acc - prev_acc, 3);
        wait_idle();

        // Slave error on a read: o_rdata keeps 0xBB
        issue(1'b0, 8'h07, 8'h00, 0, 1'b1, 8'h55, 1'b0);
        wait_idle();
        // Write with slave error and one wait
        issue(1'b1, 8'h08, 8'h11, 1, 1'b1, 8'h00, 1'b0);
        wait_idle();
        // Hung slave: timeout abort
        issue(1'b0, 8'h20, 8'h00, STUCK, 1'b0, 8'h99, 1'b0);
        wait_idle();
        // Status clears at the next accept; new read data lands
        issue(1'b0, 8'h09, 8'h00, 0, 1'b0, 8'h3C, 1'b0);
        wait_idle();
        // Longest wait that still completes
        issue(1'b0, 8'h0A, 8'h00, TIMEOUT - 1, 1'b0, 8'hA5, 1'b0);
        wait_idle();

        // Reset during the second ACCESS wait cycle
        issue(1'b0, 8'h30, 8'h00, STUCK, 1'b0, 8'h77, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        dc = done_count;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state();
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_count, dc);

        // Normal traffic after reset
        issue(1'b1, 8'h40, 8'h5A, 0, 1'b0, 8'h00, 1'b0);
        wait_idle();
        issue(1'b0, 8'h40, 8'h00, 3, 1'b0, 8'h5A, 1'b0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester (initiator) that drives the same APB bus our `apb_slave` responds on. A local command interface issues single read/write transfers. The block sequences them through IDLE → SETUP → ACCESS, honours PREADY wait states, captures PRDATA and PSLVERR, and aborts a hung transfer after a programmable wait-state limit. It sits between a bus-owning agent (sequencer, CPU bridge, bench driver) and one or more APB slaves behind an external decoder.

## Interface
- `WDATA`, 8, data width (PWDATA/PRDATA/command data).
- `WADDR`, 8, address width.
- `TIMEOUT`, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout.

- `i_PCLK`  in  1  single clock, all logic on rising edge.
- `i_PRESETn`  in  1  reset; synchronous, active-low.
- `i_req`  in  1  command valid.
- `i_write`  in  1  1 = write, 0 = read.
- `i_addr`  in  WADDR  command address.
- `i_wdata`  in  WDATA  command write data.
- `o_cmd_ready`  out  1  command accepted when `i_req && o_cmd_ready` at a clock edge.
- `o_done`  out  1  one-cycle completion pulse.
- `o_rdata`  out  WDATA  read data of the last completed successful read.
- `o_err`  out  1  completion status: slave error or timeout.
- `o_timeout`  out  1  completion was a timeout abort.
- `o_PSELx`  out  1  APB select.
- `o_PENABLE`  out  1  APB enable.
- `o_PWRITE`  out  1  APB direction.
- `o_PADDR`  out  WADDR  APB address.
- `o_PWDATA`  out  WDATA  APB write data.
- `i_PREADY`  in  1  slave ready / wait-state control.
- `i_PSLVERR`  in  1  slave error; sampled only when PREADY=1 in ACCESS.
- `i_PRDATA`  in  WDATA  slave read data; sampled only when PREADY=1 in ACCESS of a read.

## Operation
- States:
  - IDLE: PSELx=0, PENABLE=0, o_cmd_ready=1.
  - SETUP: PSELx=1, PENABLE=0.
  - ACCESS: PSELx=1, PENABLE=1.
  - o_cmd_ready=0 in SETUP and ACCESS.
- IDLE → SETUP on accepted command. PADDR, PWRITE, PWDATA are registered from `i_addr`/`i_write`/`i_wdata` at the accepting edge. They hold stable until the next accept, including after completion.
- SETUP → ACCESS unconditionally after one cycle. The wait counter is cleared.
- ACCESS with PREADY=1 → IDLE:
  - o_done=1 for one cycle.
  - o_err=PSLVERR, o_timeout=0.
  - On a read, o_rdata=PRDATA, but only if PSLVERR=0; otherwise o_rdata is unchanged.
  - On a write, o_rdata is unchanged.
- ACCESS with PREADY=0 → wait counter +1, stay in ACCESS.
  - If TIMEOUT≠0 and the counter equals TIMEOUT-1 at that edge → IDLE, o_done=1, o_err=1, o_timeout=1, o_rdata unchanged.
- Counter width is $clog2(TIMEOUT+1). The counter never wraps; it is only ever compared, then cleared.
- o_err and o_timeout hold their value until the next completion. They are cleared at the next accept.
- `i_req` and command fields are ignored while o_cmd_ready=0. There is no queueing; the requester must hold `i_req` until accepted.

## Timing
- Reset (PRESETn=0 at an edge): state IDLE; o_PSELx, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA, o_rdata, o_done, o_err, o_timeout all 0; o_cmd_ready=1 from the first post-reset cycle.
- Zero-wait transfer, accept at edge N:
  - SETUP in cycle N..N+1.
  - ACCESS in cycle N+1..N+2; PREADY sampled at edge N+2.
  - o_done high in cycle N+2..N+3.
- Each PREADY=0 cycle adds exactly one cycle of latency.
- o_cmd_ready returns high in the same cycle o_done is high, so the next accept can occur at edge N+3. Back-to-back throughput is 3 cycles per zero-wait transfer.
- PSELx deasserts for at least one cycle between transfers.
- Timeout: with PREADY stuck low, ACCESS lasts exactly TIMEOUT cycles, then o_done/o_timeout pulse in the following cycle.
- Reset mid-transfer (SETUP or ACCESS): PSELx/PENABLE drop at the reset edge, no o_done is generated, and the counter clears.
- All outputs are registered. There is no combinational path from APB inputs to any output.

## Test plan
- Reset, then write 0x04←0xBB, PREADY=1:
  - PSELx high 2 cycles, PENABLE high 1 cycle, PADDR=0x04, PWDATA=0xBB, PWRITE=1.
  - o_done 1 cycle, 3 cycles after accept; o_err=0.
- Read 0x04 with slave holding PREADY=0 for 2 cycles, PRDATA=0xBB:
  - ACCESS lasts 3 cycles.
  - o_done 5 cycles after accept; o_rdata=0xBB, o_err=0.
- Back-to-back writes 0x05←0xCC then 0x06←0xDD, `i_req` held high:
  - Second accept in the o_done cycle of the first; transfers 3 cycles apart.
  - PSELx low exactly 1 cycle between them.
- Read 0x07 with PREADY=1, PSLVERR=1, PRDATA=0x55:
  - o_done with o_err=1, o_timeout=0; o_rdata keeps its previous value 0xBB.
- TIMEOUT=16, PREADY stuck 0:
  - Abort after 16 ACCESS cycles; o_done, o_err=1, o_timeout=1; PSELx=0 next cycle.
  - Next read with PREADY=1 clears o_err/o_timeout at accept.
- Assert PRESETn=0 in cycle 2 of an ACCESS wait state:
  - PSELx/PENABLE=0 and all outputs 0 after that edge; no o_done; next command completes normally.
